// File: rtl/control_encoder.sv
// Control-bundle to 16-bit instruction encoder with a 2-entry output FIFO.
// Illegal bundles are dropped, flagged with a one-cycle Err pulse and counted.
module control_encoder (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        In_valid,
    output logic        In_ready,
    input  logic        Branch,
    input  logic        Regdst,
    input  logic        ALUsrc,
    input  logic        Regwrite,
    input  logic        Memread,
    input  logic        Memtoreg,
    input  logic        Memwrite,
    input  logic [2:0]  ALUop,
    input  logic [3:0]  Rs,
    input  logic [3:0]  Rt,
    input  logic [3:0]  Rd,
    output logic        Out_valid,
    input  logic        Out_ready,
    output logic [15:0] Instr,
    output logic        Err,
    output logic [7:0]  Err_count
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } occ_e;

    // {Branch,Regdst,ALUsrc,Regwrite,Memread,Memtoreg,Memwrite,ALUop}
    localparam logic [9:0] BundleRtype  = 10'b0101000_100;
    localparam logic [9:0] BundleBranch = 10'b1000000_001;
    localparam logic [9:0] BundleLoad   = 10'b0011110_010;
    localparam logic [9:0] BundleStore  = 10'b0010001_010;

    occ_e        state_q, state_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [15:0] mem_q [2];
    logic [15:0] instr_q, instr_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic        err_q, err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic [9:0]  bundle;
    logic        legal;
    logic [3:0]  opcode;
    logic [15:0] new_word;
    logic        take;
    logic        push;
    logic        bad;
    logic        pop;

    always_comb begin
        bundle = {Branch, Regdst, ALUsrc, Regwrite, Memread, Memtoreg, Memwrite, ALUop};
        legal  = 1'b1;
        opcode = 4'd0;
        case (bundle)
            BundleRtype:  opcode = 4'd0;
            BundleBranch: opcode = 4'd1;
            BundleLoad:   opcode = 4'd3;
            BundleStore:  opcode = 4'd11;
            default: begin
                legal  = 1'b0;
                opcode = 4'd0;
            end
        endcase
        new_word = {opcode, Rs, Rt, Rd};
    end

    always_comb begin
        take = In_valid && in_ready_q;
        push = take && legal;
        bad  = take && !legal;
        pop  = out_valid_q && Out_ready;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: if (push) state_d = StOne;
            StOne: begin
                if (push && !pop) begin
                    state_d = StFull;
                end else if (pop && !push) begin
                    state_d = StEmpty;
                end
            end
            StFull:  if (pop) state_d = StOne;
            default: state_d = StEmpty;
        endcase

        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;

        // Next head may be the word being written this very cycle.
        if (state_d == StEmpty) begin
            instr_d = 16'h0000;
        end else if (push && (wr_ptr_q == rd_ptr_d)) begin
            instr_d = new_word;
        end else begin
            instr_d = mem_q[rd_ptr_d];
        end

        in_ready_d  = (state_d != StFull);
        out_valid_d = (state_d != StEmpty);

        err_d     = bad;
        err_cnt_d = err_cnt_q;
        if (bad && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= StEmpty;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            mem_q[0]    <= 16'h0000;
            mem_q[1]    <= 16'h0000;
            instr_q     <= 16'h0000;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            if (push) begin
                mem_q[wr_ptr_q] <= new_word;
            end
            instr_q     <= instr_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign In_ready  = in_ready_q;
    assign Out_valid = out_valid_q;
    assign Instr     = instr_q;
    assign Err       = err_q;
    assign Err_count = err_cnt_q;

endmodule

// File: tb/tb_control_encoder.sv
// Directed self-checking bench for control_encoder.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_control_encoder;

    localparam logic [9:0] BRtype   = 10'b0101000_100;
    localparam logic [9:0] BBranch  = 10'b1000000_001;
    localparam logic [9:0] BLoad    = 10'b0011110_010;
    localparam logic [9:0] BStore   = 10'b0010001_010;
    localparam logic [9:0] BZero    = 10'b0000000_000;
    localparam logic [9:0] BRtypeOp = 10'b0101000_101;

    logic        Clk;
    logic        Rst;
    logic        In_valid;
    logic        In_ready;
    logic        Branch, Regdst, ALUsrc, Regwrite, Memread, Memtoreg, Memwrite;
    logic [2:0]  ALUop;
    logic [3:0]  Rs, Rt, Rd;
    logic        Out_valid;
    logic        Out_ready;
    logic [15:0] Instr;
    logic        Err;
    logic [7:0]  Err_count;
    logic [9:0]  bun;

    int checks;
    int errors;

    assign {Branch, Regdst, ALUsrc, Regwrite, Memread, Memtoreg, Memwrite, ALUop} = bun;

    control_encoder dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .In_valid  (In_valid),
        .In_ready  (In_ready),
        .Branch    (Branch),
        .Regdst    (Regdst),
        .ALUsrc    (ALUsrc),
        .Regwrite  (Regwrite),
        .Memread   (Memread),
        .Memtoreg  (Memtoreg),
        .Memwrite  (Memwrite),
        .ALUop     (ALUop),
        .Rs        (Rs),
        .Rt        (Rt),
        .Rd        (Rd),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready),
        .Instr     (Instr),
        .Err       (Err),
        .Err_count (Err_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [9:0] b, input logic [3:0] rs, input logic [3:0] rt,
                         input logic [3:0] rd);
        bun      = b;
        Rs       = rs;
        Rt       = rt;
        Rd       = rd;
        In_valid = 1'b1;
    endtask

    task automatic idle();
        In_valid = 1'b0;
        bun      = BZero;
    endtask

    task automatic step();
        @(negedge Clk);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        Rst       = 1'b1;
        In_valid  = 1'b0;
        Out_ready = 1'b0;
        bun       = BZero;
        Rs        = 4'h0;
        Rt        = 4'h0;
        Rd        = 4'h0;
        step();
        step();
        Rst = 1'b0;

        check("rst_out_valid", 32'(Out_valid), 32'd0);
        check("rst_instr", 32'(Instr), 32'h0);
        check("rst_err", 32'(Err), 32'd0);
        check("rst_err_count", 32'(Err_count), 32'd0);
        check("rst_in_ready", 32'(In_ready), 32'd1);

        // R-type straight through
        Out_ready = 1'b1;
        drive(BRtype, 4'h2, 4'h3, 4'h4);
        step();
        idle();
        check("rtype_valid", 32'(Out_valid), 32'd1);
        check("rtype_instr", 32'(Instr), 32'h0234);
        step();
        check("rtype_drained", 32'(Out_valid), 32'd0);
        check("rtype_instr_zero", 32'(Instr), 32'h0);

        // Load then store with downstream stalled
        Out_ready = 1'b0;
        drive(BLoad, 4'h1, 4'h5, 4'h7);
        step();
        drive(BStore, 4'h2, 4'h6, 4'h8);
        step();
        idle();
        check("full_in_ready", 32'(In_ready), 32'd0);
        check("full_head", 32'(Instr), 32'h3157);
        step();
        check("stall_stable_valid", 32'(Out_valid), 32'd1);
        check("stall_stable_instr", 32'(Instr), 32'h3157);
        Out_ready = 1'b1;
        step();
        check("pop1_instr", 32'(Instr), 32'hB268);
        check("pop1_in_ready", 32'(In_ready), 32'd1);
        step();
        check("pop2_valid", 32'(Out_valid), 32'd0);
        Out_ready = 1'b0;

        // Illegal bundles
        drive(BZero, 4'h9, 4'h9, 4'h9);
        step();
        idle();
        check("ill_err", 32'(Err), 32'd1);
        check("ill_count", 32'(Err_count), 32'd1);
        check("ill_no_push", 32'(Out_valid), 32'd0);
        drive(BRtypeOp, 4'h1, 4'h1, 4'h1);
        step();
        idle();
        check("ill_aluop_err", 32'(Err), 32'd1);
        check("ill_aluop_count", 32'(Err_count), 32'd2);
        check("ill_aluop_no_push", 32'(Out_valid), 32'd0);
        step();
        check("ill_err_pulse_end", 32'(Err), 32'd0);
        drive(BZero, 4'h0, 4'h0, 4'h0);
        repeat (300) step();
        idle();
        check("sat_count", 32'(Err_count), 32'd255);
        check("sat_err", 32'(Err), 32'd1);
        step();
        check("sat_hold", 32'(Err_count), 32'd255);
        check("sat_err_low", 32'(Err), 32'd0);

        // Simultaneous push and pop in ONE
        drive(BRtype, 4'h1, 4'h2, 4'h3);
        step();
        check("one_head", 32'(Instr), 32'h0123);
        drive(BBranch, 4'hA, 4'hB, 4'hC);
        Out_ready = 1'b1;
        step();
        idle();
        Out_ready = 1'b0;
        check("pp_valid", 32'(Out_valid), 32'd1);
        check("pp_instr", 32'(Instr), 32'h1ABC);
        check("pp_in_ready", 32'(In_ready), 32'd1);
        Out_ready = 1'b1;
        step();
        check("pp_drained", 32'(Out_valid), 32'd0);
        Out_ready = 1'b0;

        // FULL with pop and In_valid: nothing enters
        drive(BLoad, 4'h4, 4'h4, 4'h4);
        step();
        drive(BStore, 4'h5, 4'h5, 4'h5);
        step();
        drive(BBranch, 4'h6, 4'h6, 4'h6);
        Out_ready = 1'b1;
        step();
        idle();
        check("full_pop_instr", 32'(Instr), 32'hB555);
        step();
        check("full_pop_no_push", 32'(Out_valid), 32'd0);
        Out_ready = 1'b0;

        // Reset with buffered entries and a bundle on the inputs
        drive(BLoad, 4'h7, 4'h7, 4'h7);
        step();
        drive(BStore, 4'h8, 4'h8, 4'h8);
        step();
        drive(BZero, 4'h0, 4'h0, 4'h0);
        step();
        check("pre_rst_count", 32'(Err_count), 32'd255);
        drive(BRtype, 4'hD, 4'hE, 4'hF);
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        idle();
        check("mid_rst_valid", 32'(Out_valid), 32'd0);
        check("mid_rst_instr", 32'(Instr), 32'h0);
        check("mid_rst_count", 32'(Err_count), 32'd0);
        check("mid_rst_in_ready", 32'(In_ready), 32'd1);
        step();
        check("mid_rst_no_entry", 32'(Out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
